// File: rtl/sc_lane_scroll_scheduler.sv
// sc_lane_scroll_scheduler
// Per-lane scroll-period countdowns raise pending requests; one shared
// shift/column-count datapath serves them one lane at a time.
// After the one-cycle LOAD and the WAITSTART hold, each grant takes
// IDLE -> SHIFT -> COUNT.
// Optional build macro SC_LANESCHED_FIXED_PRIORITY_EN: arbitration becomes
// fixed priority (lane 0 highest) and the round-robin pointer is removed.
module sc_lane_scroll_scheduler #(
  parameter int LANE_COUNT   = 4,
  parameter int PERIOD_WIDTH = 8
) (
  input  logic                               SC_LANESCHED_CLOCK_50,
  input  logic                               SC_LANESCHED_RESET_InLow,
  input  logic                               SC_LANESCHED_tick_In,
  input  logic                               SC_LANESCHED_startGame_InLow,
  input  logic                               SC_LANESCHED_pause_InLow,
  input  logic [LANE_COUNT*PERIOD_WIDTH-1:0] SC_LANESCHED_period_InBus,
  input  logic [LANE_COUNT-1:0]              SC_LANESCHED_dir_InBus,
  output logic [2*LANE_COUNT-1:0]            SC_LANESCHED_shiftselection_OutBus,
  output logic                               SC_LANESCHED_upcount_OutLow,
  output logic [LANE_COUNT-1:0]              SC_LANESCHED_grant_OutBus,
  output logic [LANE_COUNT-1:0]              SC_LANESCHED_overrun_OutBus
);

  localparam int RW = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;

  typedef enum logic [2:0] {
    ST_LOAD, ST_WAITSTART, ST_IDLE, ST_SHIFT, ST_COUNT
  } state_t;

  state_t                  r_state, w_state_next;
  logic [PERIOD_WIDTH-1:0] r_cnt [LANE_COUNT];
  logic [LANE_COUNT-1:0]   r_pending, r_overrun, r_grant;
  logic [LANE_COUNT-1:0]   w_set, w_clr, w_grant_onehot;
  logic                    w_cnt_en, w_found, w_grant_fire;
  logic [RW-1:0]           w_grant_idx;
`ifndef SC_LANESCHED_FIXED_PRIORITY_EN
  logic [RW-1:0]           r_rr;
  logic [LANE_COUNT-1:0]   w_rot;
  logic [RW:0]             w_sum;
`endif

  // Countdown enable and per-lane expiry detection.
  always_comb begin
    w_cnt_en = SC_LANESCHED_tick_In && SC_LANESCHED_pause_InLow &&
               (r_state != ST_LOAD) && (r_state != ST_WAITSTART);
    for (int i = 0; i < LANE_COUNT; i++) begin
      w_set[i] = w_cnt_en && (r_cnt[i] == '0) &&
                 (SC_LANESCHED_period_InBus[i*PERIOD_WIDTH +: PERIOD_WIDTH] != '0);
    end
  end

  // Pick the lane to serve next from the pending set.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
`ifdef SC_LANESCHED_FIXED_PRIORITY_EN
    for (int k = LANE_COUNT - 1; k >= 0; k--) begin
      if (r_pending[k]) begin
        w_found     = 1'b1;
        w_grant_idx = RW'(k);
      end
    end
`else
    // Rotate so bit k means lane (rr + k); the lowest set k is the winner.
    w_rot = LANE_COUNT'({r_pending, r_pending} >> r_rr);
    w_sum = '0;
    for (int k = LANE_COUNT - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr} + (RW+1)'(k);
        if (w_sum >= (RW+1)'(LANE_COUNT)) w_sum = w_sum - (RW+1)'(LANE_COUNT);
        w_grant_idx = w_sum[RW-1:0];
      end
    end
`endif
    w_grant_onehot = LANE_COUNT'(1) << w_grant_idx;
  end

  // Next-state and output decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_next                       = r_state;
    w_grant_fire                       = 1'b0;
    SC_LANESCHED_shiftselection_OutBus = '1;
    SC_LANESCHED_upcount_OutLow        = 1'b1;
    SC_LANESCHED_grant_OutBus          = '0;
    case (r_state)
      ST_LOAD: begin
        SC_LANESCHED_shiftselection_OutBus = '0;
        w_state_next                       = ST_WAITSTART;
      end
      ST_WAITSTART: begin
        if (SC_LANESCHED_startGame_InLow) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (!SC_LANESCHED_startGame_InLow) begin
          w_state_next = ST_LOAD;
        end else if (SC_LANESCHED_pause_InLow && w_found) begin
          w_grant_fire = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        SC_LANESCHED_grant_OutBus = r_grant;
        for (int i = 0; i < LANE_COUNT; i++) begin
          if (r_grant[i])
            SC_LANESCHED_shiftselection_OutBus[2*i +: 2] =
              SC_LANESCHED_dir_InBus[i] ? 2'b10 : 2'b01;
        end
        w_state_next = ST_COUNT;
      end
      ST_COUNT: begin
        SC_LANESCHED_upcount_OutLow = 1'b0;
        SC_LANESCHED_grant_OutBus   = r_grant;
        w_state_next                = ST_IDLE;
      end
      default: w_state_next = ST_LOAD;
    endcase
    // Outputs go idle the instant reset asserts, not at the next edge.
    if (!SC_LANESCHED_RESET_InLow) begin
      SC_LANESCHED_shiftselection_OutBus = '1;
      SC_LANESCHED_upcount_OutLow        = 1'b1;
      SC_LANESCHED_grant_OutBus          = '0;
    end
    w_clr = w_grant_fire ? w_grant_onehot : '0;
  end

  assign SC_LANESCHED_overrun_OutBus = r_overrun;

  // FSM state register.
  always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET_InLow) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!SC_LANESCHED_RESET_InLow) r_state <= ST_LOAD;
    else                           r_state <= w_state_next;
  end

  // Lane countdowns, pending requests and sticky overrun flags.
  always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET_InLow) begin
    if (!SC_LANESCHED_RESET_InLow) begin
      // NOTE: the counter array is a handful of flops, so it is reset like any other state.
      for (int i = 0; i < LANE_COUNT; i++) r_cnt[i] <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else if (r_state == ST_LOAD) begin
      for (int i = 0; i < LANE_COUNT; i++) begin
        if (SC_LANESCHED_period_InBus[i*PERIOD_WIDTH +: PERIOD_WIDTH] != '0)
          r_cnt[i] <= SC_LANESCHED_period_InBus[i*PERIOD_WIDTH +: PERIOD_WIDTH]
                      - PERIOD_WIDTH'(1);
        else
          r_cnt[i] <= '0;
      end
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      for (int i = 0; i < LANE_COUNT; i++) begin
        if (w_set[i])
          r_cnt[i] <= SC_LANESCHED_period_InBus[i*PERIOD_WIDTH +: PERIOD_WIDTH]
                      - PERIOD_WIDTH'(1);
        else if (w_cnt_en && r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - PERIOD_WIDTH'(1);
      end
      // A same-cycle set and clear leaves the request pending without overrun.
      r_pending <= w_set | (r_pending & ~w_clr);
      r_overrun <= r_overrun | (w_set & r_pending & ~w_clr);
    end
  end

  // Registered grant and round-robin pointer.
  always_ff @(posedge SC_LANESCHED_CLOCK_50 or negedge SC_LANESCHED_RESET_InLow) begin
    if (!SC_LANESCHED_RESET_InLow) begin
      r_grant <= '0;
`ifndef SC_LANESCHED_FIXED_PRIORITY_EN
      r_rr    <= '0;
`endif
    end else if (r_state == ST_LOAD) begin
      r_grant <= '0;
`ifndef SC_LANESCHED_FIXED_PRIORITY_EN
      r_rr    <= '0;
`endif
    end else if (w_grant_fire) begin
      r_grant <= w_grant_onehot;
`ifndef SC_LANESCHED_FIXED_PRIORITY_EN
      r_rr    <= (w_grant_idx == RW'(LANE_COUNT - 1)) ? '0 : w_grant_idx + RW'(1);
`endif
    end else if (r_state == ST_COUNT) begin
      r_grant <= '0;
    end
  end

endmodule

// File: tb/tb_sc_lane_scroll_scheduler.sv
// tb_sc_lane_scroll_scheduler
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model: a lane requests on every enabled tick
// whose count since LOAD is a multiple of its period, and the arbiter serves
// one request per three-cycle IDLE/SHIFT/COUNT slot.
module tb_sc_lane_scroll_scheduler;

  localparam int N  = 4;
  localparam int PW = 8;
  localparam int P_LOAD = 0, P_WAIT = 1, P_IDLE = 2, P_SHIFT = 3, P_COUNT = 4;

  logic            clk = 1'b0;
  logic            rst_n, tick, start_n, pause_n;
  logic [N*PW-1:0] period;
  logic [N-1:0]    dir;
  logic [2*N-1:0]  sel;
  logic            upcount_n;
  logic [N-1:0]    grant, overrun;

  sc_lane_scroll_scheduler #(.LANE_COUNT(N), .PERIOD_WIDTH(PW)) dut (
    .SC_LANESCHED_CLOCK_50              (clk),
    .SC_LANESCHED_RESET_InLow           (rst_n),
    .SC_LANESCHED_tick_In               (tick),
    .SC_LANESCHED_startGame_InLow       (start_n),
    .SC_LANESCHED_pause_InLow           (pause_n),
    .SC_LANESCHED_period_InBus          (period),
    .SC_LANESCHED_dir_InBus             (dir),
    .SC_LANESCHED_shiftselection_OutBus (sel),
    .SC_LANESCHED_upcount_OutLow        (upcount_n),
    .SC_LANESCHED_grant_OutBus          (grant),
    .SC_LANESCHED_overrun_OutBus        (overrun)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.
  int m_phase;
  int m_per   [N];
  int m_ticks [N];
  bit m_pend  [N];
  bit m_ovr   [N];
  int m_rr, m_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_LOAD;
    m_rr    = 0;
    m_gnt   = 0;
    for (int i = 0; i < N; i++) begin
      m_per[i] = 0; m_ticks[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
  endtask

  // Advance one clock using the inputs present at the edge.
  task automatic model_step();
    bit sets [N];
    bit en;
    int pick;
    pick = -1;
    if (m_phase == P_LOAD) begin
      for (int i = 0; i < N; i++) begin
        m_per[i] = int'(period[i*PW +: PW]);
        m_ticks[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
      end
      m_rr = 0;
      m_phase = P_WAIT;
      return;
    end
    en = tick && pause_n && (m_phase != P_WAIT);
    for (int i = 0; i < N; i++) begin
      sets[i] = en && (m_per[i] != 0) && (((m_ticks[i] + 1) % (m_per[i] == 0 ? 1 : m_per[i])) == 0);
      if (en) m_ticks[i]++;
    end
    if (m_phase == P_IDLE && start_n && pause_n) begin
`ifdef SC_LANESCHED_FIXED_PRIORITY_EN
      for (int k = 0; k < N; k++) if (pick < 0 && m_pend[k]) pick = k;
`else
      for (int k = 0; k < N; k++) if (pick < 0 && m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (sets[i] && m_pend[i] && (i != pick)) m_ovr[i] = 1;
      m_pend[i] = sets[i] || (m_pend[i] && (i != pick));
    end
    case (m_phase)
      P_WAIT:  if (start_n) m_phase = P_IDLE;
      P_IDLE:  if (!start_n) m_phase = P_LOAD;
               else if (pick >= 0) begin m_phase = P_SHIFT; m_gnt = pick; m_rr = (pick + 1) % N; end
      P_SHIFT: m_phase = P_COUNT;
      default: m_phase = P_IDLE;
    endcase
  endtask

  // One clock: drive inputs on the falling edge, compare shortly after, step the model on the rising edge.
  task automatic cyc(input bit r, input bit t, input bit s, input bit p, input logic [N-1:0] d);
    logic [2*N-1:0] e_sel;
    logic           e_up;
    logic [N-1:0]   e_g, e_ovr;
    @(negedge clk);
    rst_n = r; tick = t; start_n = s; pause_n = p; dir = d;
    if (!r) model_reset();
    #1;
    e_sel = '1; e_up = 1'b1; e_g = '0;
    for (int i = 0; i < N; i++) e_ovr[i] = m_ovr[i];
    if (r) begin
      case (m_phase)
        P_LOAD:  e_sel = '0;
        P_SHIFT: begin
          e_g = N'(1) << m_gnt;
          e_sel[2*m_gnt +: 2] = d[m_gnt] ? 2'b10 : 2'b01;
        end
        P_COUNT: begin e_up = 1'b0; e_g = N'(1) << m_gnt; end
        default: ;
      endcase
    end
    check("shiftselection", 32'(sel), 32'(e_sel));
    check("upcount_n", 32'(upcount_n), 32'(e_up));
    check("grant", 32'(grant), 32'(e_g));
    check("overrun", 32'(overrun), 32'(e_ovr));
    @(posedge clk);
    if (r) model_step();
  endtask

  task automatic wait_phase(input int target, input bit t, input string tag);
    for (int k = 0; k < 40 && m_phase != target; k++) cyc(1, t, 1, 1, 4'($urandom));
    check(tag, 32'(m_phase), 32'(target));
  endtask

  // Return to IDLE, then run IDLE -> LOAD -> WAITSTART -> IDLE with new periods.
  task automatic do_load(input logic [N*PW-1:0] per);
    wait_phase(P_IDLE, 0, "wait_idle_timeout");
    period = per;
    cyc(1, 0, 0, 1, '1);
    cyc(1, 0, 0, 1, '1);
    cyc(1, 0, 1, 1, '1);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; start_n = 1'b1; pause_n = 1'b1; dir = '0;
    period = {8'd0, 8'd0, 8'd3, 8'd0};
    model_reset();

    // Reset, then LOAD, WAITSTART held by startGame low, then IDLE.
    repeat (3) cyc(0, 0, 1, 1, '0);
    cyc(1, 0, 0, 1, '0);
    cyc(1, 0, 0, 1, '0);
    cyc(1, 0, 1, 1, '0);
    cyc(1, 0, 1, 1, '0);

    // Lane 1 period 3, shifting left, tick every cycle.
    repeat (16) cyc(1, 1, 1, 1, 4'b0010);

    // Lanes 0, 2, 3 expire together; round-robin serves 0, 2, 3.
    do_load({8'd4, 8'd4, 8'd0, 8'd4});
    repeat (20) cyc(1, 1, 1, 1, 4'b1010);

    // Lane 0 period 1 re-pends while pending: overrun, then cleared by LOAD.
    do_load({8'd0, 8'd0, 8'd0, 8'd1});
    repeat (10) cyc(1, 1, 1, 1, 4'b0001);
    do_load('0);
    cyc(1, 0, 1, 1, '0);

    // Pause during SHIFT: COUNT still completes, then everything freezes.
    do_load({8'd0, 8'd2, 8'd0, 8'd3});
    wait_phase(P_SHIFT, 1, "wait_shift_timeout");
    repeat (5) cyc(1, 1, 1, 0, 4'b0100);
    repeat (10) cyc(1, 1, 1, 1, 4'b0000);

    // Asynchronous reset in the middle of a COUNT cycle.
    wait_phase(P_COUNT, 1, "wait_count_timeout");
    cyc(0, 1, 1, 1, '0);
    cyc(0, 1, 1, 1, '0);
    cyc(1, 0, 1, 1, '0);

    // Randomized traffic with fresh periods each round.
    for (int round = 0; round < 12; round++) begin
      logic [N*PW-1:0] per;
      for (int i = 0; i < N; i++) per[i*PW +: PW] = PW'($urandom_range(0, 6));
      do_load(per);
      for (int c = 0; c < 150; c++)
        cyc(1, ($urandom_range(0, 9) < 7), 1, ($urandom_range(0, 9) != 0), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sc_lane_scroll_scheduler.md
Name: sc_lane_scroll_scheduler

Overview:
- Schedules background lane scrolling for the frogger playfield.
- Each lane has its own scroll period, counted in base ticks. Lanes whose period expires raise a pending request.
- Pending requests are serialized onto the shared shift/column-count datapath, one lane at a time, in round-robin order.
- Drives per-lane shift-selection codes and the active-low column-count strobe.
- Also sequences the playfield LOAD at game start.

Parameters:
- LANE_COUNT, 4, number of scrolling lanes (2..8).
- PERIOD_WIDTH, 8, width of each lane's period field and of its countdown counter.

Ports:
- SC_LANESCHED_CLOCK_50  in  1  system clock.
- SC_LANESCHED_RESET_InLow  in  1  reset, asynchronous, active-low.
- SC_LANESCHED_tick_In  in  1  one-cycle base-tick pulse from the prescaler.
- SC_LANESCHED_startGame_InLow  in  1  level; low requests playfield load.
- SC_LANESCHED_pause_InLow  in  1  level; low freezes scrolling.
- SC_LANESCHED_period_InBus  in  LANE_COUNT*PERIOD_WIDTH  per-lane reload value; lane i occupies bits [i*PW +: PW]; 0 = lane frozen.
- SC_LANESCHED_dir_InBus  in  LANE_COUNT  per-lane direction; 1 = left, 0 = right.
- SC_LANESCHED_shiftselection_OutBus  out  2*LANE_COUNT  per-lane code: 11 hold, 10 shift left, 01 shift right, 00 load.
- SC_LANESCHED_upcount_OutLow  out  1  column-count strobe, active-low.
- SC_LANESCHED_grant_OutBus  out  LANE_COUNT  one-hot grant; high during SHIFT and COUNT.
- SC_LANESCHED_overrun_OutBus  out  LANE_COUNT  sticky per-lane overrun flag.

Behaviour:
Reset (asynchronous, RESET_InLow = 0):
- FSM enters LOAD.
- Countdown counters, pending bits, overrun flags and the rr pointer all go to 0.
- Outputs during reset: shiftselection all 11, upcount_OutLow = 1, grant = 0.

Per-lane countdown:
- Counters update only when tick_In = 1 and pause_InLow = 1 and the FSM is not in LOAD or WAITSTART.
- If period = 0: the counter holds 0 and the lane never requests.
- If counter = 0 and period != 0: reload to period-1 and set pending[i].
- Otherwise: decrement by 1.
- A period of N therefore gives one request every N ticks.
- A period change takes effect at the next reload.

Pending bits:
- A set and a clear of the same lane in the same cycle leaves pending = 1; overrun is not set.
- A set while pending is already 1 (and not being cleared) sets overrun[i] = 1. overrun clears only on reset or LOAD.

States:
- LOAD (1 cycle):
  - shiftselection = 00 on all lanes.
  - Clears pending and overrun; loads each counter with period-1 (0 if period = 0); rr pointer = 0.
  - Next state: WAITSTART.
- WAITSTART:
  - All lanes 11.
  - Stays while startGame_InLow = 0; goes to IDLE when it is 1.
- IDLE:
  - All lanes 11.
  - startGame_InLow = 0 has priority: go to LOAD.
  - Else, if pause_InLow = 1 and any pending bit is set: pick the first pending lane at or after the rr pointer (modulo LANE_COUNT), register it as the grant, clear its pending bit, set rr = lane+1 mod LANE_COUNT, go to SHIFT.
  - Else stay in IDLE.
- SHIFT (1 cycle):
  - Granted lane outputs 10 if dir = 1, 01 if dir = 0; all other lanes output 11.
  - Next state: COUNT.
- COUNT (1 cycle):
  - upcount_OutLow = 0; all lanes 11.
  - Next state: IDLE.

Timing and boundary rules:
- Minimum service interval per grant: 3 cycles (IDLE, SHIFT, COUNT). Latency from the tick that expires a counter to SHIFT: 2 cycles when the FSM is idle.
- Pause or startGame asserted during SHIFT or COUNT: the current grant still completes. startGame is then acted on in the next IDLE.
- dir is sampled in SHIFT, not at grant time.
- Reset asserted mid-operation: takes effect immediately and asynchronously; outputs return to their reset values.

Optional Feature:
- Macro: SC_LANESCHED_FIXED_PRIORITY_EN.
- Defined: IDLE always grants the lowest-index pending lane. The rr pointer is removed and lane 0 has highest priority.
- Undefined: round-robin arbitration as specified above.

Test Plan:
1. Reset, then startGame_InLow pulsed low then high → one LOAD cycle with shiftselection = 00000000 (LANE_COUNT = 4), then WAITSTART, then IDLE; grant = 0.
2. Lane 1 period = 3, dir = 1, tick every cycle, other lanes period 0 → lane 1 code 10 every 3 ticks, each SHIFT followed by exactly one COUNT cycle with upcount_OutLow = 0.
3. Lanes 0, 2 and 3 all pending in the same cycle, rr = 0 → grant order 0001, 0100, 1000, each 3 cycles apart; rr ends at 0. With SC_LANESCHED_FIXED_PRIORITY_EN defined and lane 0 re-pending → lane 0 is served before 2 and 3.
4. Lane 0 period = 1 with tick every cycle (pending re-set while still pending) → overrun = 0001; it stays set until startGame_InLow = 0 triggers LOAD, then reads 0000.
5. pause_InLow = 0 during SHIFT → the COUNT cycle still occurs; no further grants and counters frozen while paused; granting resumes the cycle after pause_InLow = 1.
6. Reset driven low during COUNT → upcount_OutLow = 1 and shiftselection all 11 immediately (asynchronous), FSM in LOAD, pending = 0.
